alu_op_sink: RTL and testbench
==============================

# alu_op_sink

Result-collection stage directly downstream of the 3-stage arithmetic pipeline (F = ((a+b)+(c-d))*d, N-bit, truncated). That pipeline carries no valid or reset, so this block does three things:
- tracks in-flight operations with a latency-matched valid shift register;
- captures each F into a small FIFO, presented on a valid/ready output;
- keeps a saturating running sum and a result count.

It also issues credit (`issue_ready`) back to the operand source, so no result is ever lost when the source obeys it.

## Interface
- N, 10, data width of F (matches the arithmetic pipeline)
- LAT, 3, pipeline latency in clk1 edges from operand sample to F valid
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ACC_W, 16, accumulator width (≥N)

Ports:
- clk1  in  1  clock, shared with the arithmetic pipeline
- rst_n  in  1  asynchronous active-low reset
- issue  in  1  operands a,b,c,d presented to the pipeline this cycle are a real operation
- issue_ready  out  1  credit: an issue this cycle is guaranteed a FIFO slot
- F  in  N  pipeline result
- out_data  out  N  FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head
- acc_clr  in  1  synchronous clear of acc_sum and res_cnt
- acc_sum  out  ACC_W  saturating sum of all captured results
- res_cnt  out  8  captured-result count, wraps 255→0
- ovf  out  1  sticky: a result was dropped (issue while !issue_ready)

## Operation
- Valid shift register `v[0..LAT-1]`:
  - each edge: v[0]←issue, v[i]←v[i-1].
  - capture = v[LAT-1]; F is sampled on the edge where capture is 1.
- FIFO push/pop:
  - push = capture AND (count<DEPTH OR pop).
  - pop = out_valid AND out_ready.
  - Push and pop on the same edge: count unchanged, both succeed, including when full.
  - capture while full and no pop: result dropped, ovf←1 (sticky until reset).
- Credit: issue_ready = (count + popcount(v)) < DEPTH.
  - Combinational from registered state only; no dependence on out_ready or issue.
- Accumulator:
  - On capture (pushed or dropped): acc_sum ← min(acc_sum + F, 2^ACC_W−1), zero-extended add; res_cnt ← res_cnt+1.
  - acc_clr alone: acc_sum←0, res_cnt←0.
  - acc_clr with capture on the same edge: acc_sum←F, res_cnt←1 (clear then add).
- Outputs:
  - out_data is the registered head entry; it holds while out_valid & !out_ready.
- Reset (async, rst_n=0):
  - v←0, so in-flight results are discarded; the arithmetic pipeline is not reset and its stale F is ignored.
  - count←0, pointers←0, storage←0.
  - out_valid=0, out_data=0, issue_ready=1, acc_sum=0, res_cnt=0, ovf=0.
  - Outputs follow reset immediately, not at the next edge.

## Timing
- issue sampled at edge k; F sampled at edge k+LAT.
  - out_valid rises after edge k+LAT when the FIFO was empty.
  - acc_sum and res_cnt update after edge k+LAT.
- Back-to-back issues every cycle yield one capture per cycle, LAT edges later.
- issue_ready reflects state after the previous edge, so an issue in the same cycle as a pop does not get the freed slot until the next cycle.
- Once an issue is counted in popcount(v) (from edge k until capture at edge k+LAT), it holds its slot; the earliest release is at capture with simultaneous pop.
- No combinational path from any input to any output except rst_n.

## Test plan
1. Single op:
   - Stimulus: reset, then issue=1 with a=3, b=4, c=10, d=2 at edge 1.
   - Response: out_valid rises after edge 4, out_data=30, acc_sum=30, res_cnt=1; pop with out_ready=1 → out_valid=0.
2. Credit/full:
   - Stimulus: out_ready=0, issue held high.
   - Response: issue_ready falls after 4 issues; exactly 4 entries captured; ovf stays 0.
   - Then out_ready=1: entries drain in order.
3. Overflow:
   - Stimulus: with FIFO full and out_ready=0, force issue=1 while issue_ready=0.
   - Response: after LAT edges ovf=1, count stays 4, res_cnt still increments.
4. Saturation:
   - Stimulus: ACC_W=10; issue results 1000 then 100.
   - Response: acc_sum=1023 and holds there.
   - acc_clr on the same edge as a capture of 7 → acc_sum=7, res_cnt=1.
5. Reset mid-flight:
   - Stimulus: issue 2 ops, assert rst_n=0 for one cycle before their capture.
   - Response: all outputs at reset values immediately; no capture afterwards; issue_ready=1.
6. Simultaneous push/pop when full:
   - Stimulus: FIFO full and out_ready=1 on the edge of a capture.
   - Response: count stays 4, no drop, data order preserved.

Source files
------------

// File: rtl/alu_op_sink_if.sv
// Handshake and status bundle between the result-collection stage and its
// operand source / result consumer.
interface alu_op_sink_if #(
  parameter int N     = 10,
  parameter int ACC_W = 16
);
  logic             issue;
  logic             issue_ready;
  logic [N-1:0]     F;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic             acc_clr;
  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       res_cnt;
  logic             ovf;

  modport master (
    output issue, F, out_ready, acc_clr,
    input  issue_ready, out_data, out_valid, acc_sum, res_cnt, ovf
  );

  modport slave (
    input  issue, F, out_ready, acc_clr,
    output issue_ready, out_data, out_valid, acc_sum, res_cnt, ovf
  );
endinterface

// File: rtl/alu_op_sink.sv
// Collects results of the unreset 3-stage arithmetic pipeline: latency-matched
// valid tracking, result FIFO with credit, saturating running sum and count.
module alu_op_sink #(
  parameter int N     = 10,
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int ACC_W = 16
) (
  input  logic        clk1,
  input  logic        rst_n,
  alu_op_sink_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(DEPTH + LAT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] DEPTH_SC = SW'(DEPTH);

  logic [LAT-1:0]   v;
  logic [N-1:0]     mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       res_cnt;
  logic             ovf;

  logic             capture;
  logic             pop;
  logic             push;
  logic             drop;
  logic [SW-1:0]    occupancy;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_sat;

  assign capture = v[LAT-1];
  assign pop     = (count != '0) && bus.out_ready;
  assign push    = capture && ((count < DEPTH_C) || pop);
  assign drop    = capture && !push;

  // Slots already promised to in-flight operations count as occupied.
  always_comb begin
    occupancy = SW'(count);
    for (int i = 0; i < LAT; i++) begin
      occupancy = occupancy + SW'(v[i]);
    end
  end

  always_comb begin
    acc_base = bus.acc_clr ? '0 : acc_sum;
    sum_ext  = {1'b0, acc_base} + {{(ACC_W + 1 - N){1'b0}}, bus.F};
    sum_sat  = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      v[0] <= bus.issue;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.F;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Clear takes effect before a same-edge capture is added in.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum <= '0;
      res_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (capture) begin
        acc_sum <= sum_sat;
        res_cnt <= (bus.acc_clr ? 8'd0 : res_cnt) + 8'd1;
      end else if (bus.acc_clr) begin
        acc_sum <= '0;
        res_cnt <= '0;
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  assign bus.out_data    = mem[rd_ptr];
  assign bus.out_valid   = (count != '0);
  assign bus.issue_ready = (occupancy < DEPTH_SC);
  assign bus.acc_sum     = acc_sum;
  assign bus.res_cnt     = res_cnt;
  assign bus.ovf         = ovf;
endmodule

// File: tb/tb_alu_op_sink.sv
// Bench for alu_op_sink: queue-based reference of in-flight operations, FIFO
// contents and running sum, driven by directed and random stimulus.
module tb_alu_op_sink;
  localparam int N     = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int ACC_W = 10;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  alu_op_sink_if #(.N(N), .ACC_W(ACC_W)) bus ();

  alu_op_sink #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk1 (clk1),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int due;
    int val;
  } fl_t;

  fl_t infl[$];
  int  fifo_q[$];
  int  acc_m;
  int  cnt_m;
  bit  ovf_m;
  int  cyc;
  int  total;
  int  bad;

  function automatic int fcalc(int a, int b, int c, int d);
    return (((a + b) + (c - d)) * d) & ((1 << N) - 1);
  endfunction

  function automatic bit m_ready();
    return (fifo_q.size() + infl.size()) < DEPTH;
  endfunction

  task automatic model_reset();
    infl.delete();
    fifo_q.delete();
    acc_m = 0;
    cnt_m = 0;
    ovf_m = 1'b0;
  endtask

  // Drives one cycle of inputs, advances the reference, then waits past the edge.
  task automatic tick(input bit iss, input int a, input int b, input int c,
                      input int d, input bit rdy, input bit clr);
    int  nxt;
    bit  cap, pop, push;
    int  fv;
    fl_t e;
    nxt  = cyc + 1;
    cap  = (infl.size() > 0) && (infl[0].due == nxt);
    pop  = (fifo_q.size() > 0) && rdy;
    push = cap && ((fifo_q.size() < DEPTH) || pop);
    fv   = cap ? infl[0].val : int'($urandom_range(0, (1 << N) - 1));
    bus.issue     = iss;
    bus.out_ready = rdy;
    bus.acc_clr   = clr;
    bus.F         = N'(fv);
    if (pop) void'(fifo_q.pop_front());
    if (push) fifo_q.push_back(fv);
    if (cap && !push) ovf_m = 1'b1;
    if (clr) begin
      acc_m = 0;
      cnt_m = 0;
    end
    if (cap) begin
      acc_m = (acc_m + fv > ACC_MAX) ? ACC_MAX : acc_m + fv;
      cnt_m = (cnt_m + 1) % 256;
      void'(infl.pop_front());
    end
    if (iss) begin
      e.due = nxt + LAT;
      e.val = fcalc(a, b, c, d);
      infl.push_back(e);
    end
    cyc = nxt;
    @(posedge clk1);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 0, 0, rdy, 1'b0);
  endtask

  task automatic rnd_issue(input bit rdy);
    tick(1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023),
         $urandom_range(0, 1023), $urandom_range(0, 1023), rdy, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    total += 4;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%b exp=1", bus.issue_ready); end
    if (bus.acc_sum !== '0 || bus.res_cnt !== 8'd0) begin bad++; $display("FAIL reset_acc got=%0d/%0d exp=0/0", bus.acc_sum, bus.res_cnt); end
    if (bus.ovf !== 1'b0 || bus.out_data !== '0) begin bad++; $display("FAIL reset_ovf_data got=%b/%0d exp=0/0", bus.ovf, bus.out_data); end
    @(negedge clk1);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_op();
    tick(1'b1, 3, 4, 10, 2, 1'b0, 1'b0);
    idle(2, 1'b0);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", bus.out_valid); end
    idle(1, 1'b0);
    total += 4;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_data !== 10'd30) begin bad++; $display("FAIL single_data got=%0d exp=30", bus.out_data); end
    if (bus.acc_sum !== 10'd30) begin bad++; $display("FAIL single_acc got=%0d exp=30", bus.acc_sum); end
    if (bus.res_cnt !== 8'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", bus.res_cnt); end
    idle(1, 1'b1);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%b exp=0", bus.out_valid); end
  endtask

  task automatic fill_and_drain(input string tag, input bit drain);
    bit exp_rdy;
    for (int i = 0; i < 6; i++) begin
      if (m_ready()) rnd_issue(1'b0);
      else idle(1, 1'b0);
      exp_rdy = (i < 3);
      total++;
      if (bus.issue_ready !== exp_rdy) begin bad++; $display("FAIL %s_ready_%0d got=%b exp=%b", tag, i, bus.issue_ready, exp_rdy); end
    end
    idle(LAT, 1'b0);
    total++;
    if (bus.out_valid !== 1'b1 || bus.ovf !== ovf_m) begin bad++; $display("FAIL %s_full got=%b/%b exp=1/%b", tag, bus.out_valid, bus.ovf, ovf_m); end
    if (drain) begin
      for (int i = 0; i < DEPTH; i++) begin
        total++;
        if (bus.out_data !== N'(fifo_q[0])) begin bad++; $display("FAIL %s_order_%0d got=%0d exp=%0d", tag, i, bus.out_data, fifo_q[0]); end
        idle(1, 1'b1);
      end
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL %s_empty got=%b exp=0", tag, bus.out_valid); end
    end
  endtask

  task automatic test_credit_full();
    fill_and_drain("credit", 1'b1);
  endtask

  task automatic test_overflow();
    int cnt_before;
    fill_and_drain("ovfill", 1'b0);
    cnt_before = bus.res_cnt;
    rnd_issue(1'b0);
    idle(LAT, 1'b0);
    total += 3;
    if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus.ovf); end
    if (bus.res_cnt !== 8'((cnt_before + 1) % 256)) begin bad++; $display("FAIL ovf_cnt got=%0d exp=%0d", bus.res_cnt, (cnt_before + 1) % 256); end
    if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%b exp=0", bus.issue_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (bus.out_data !== N'(fifo_q[0])) begin bad++; $display("FAIL ovf_order_%0d got=%0d exp=%0d", i, bus.out_data, fifo_q[0]); end
      idle(1, 1'b1);
    end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_count got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_push_pop_full();
    fill_and_drain("ppfill", 1'b0);
    rnd_issue(1'b0);
    idle(LAT - 1, 1'b0);
    total++;
    if (bus.out_data !== N'(fifo_q[0])) begin bad++; $display("FAIL pp_head got=%0d exp=%0d", bus.out_data, fifo_q[0]); end
    idle(1, 1'b1);
    total += 3;
    if (fifo_q.size() != DEPTH) begin bad++; $display("FAIL pp_model_depth got=%0d exp=%0d", fifo_q.size(), DEPTH); end
    if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL pp_still_full got=%b exp=0", bus.issue_ready); end
    if (bus.res_cnt !== 8'(cnt_m)) begin bad++; $display("FAIL pp_cnt got=%0d exp=%0d", bus.res_cnt, cnt_m); end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (bus.out_data !== N'(fifo_q[0])) begin bad++; $display("FAIL pp_order_%0d got=%0d exp=%0d", i, bus.out_data, fifo_q[0]); end
      idle(1, 1'b1);
    end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL pp_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_saturation();
    tick(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
    total++;
    if (bus.acc_sum !== '0 || bus.res_cnt !== 8'd0) begin bad++; $display("FAIL sat_clr got=%0d/%0d exp=0/0", bus.acc_sum, bus.res_cnt); end
    tick(1'b1, 50, 50, 10, 10, 1'b1, 1'b0);
    tick(1'b1, 5, 5, 10, 10, 1'b1, 1'b0);
    idle(LAT - 1, 1'b1);
    total++;
    if (bus.acc_sum !== 10'd1000) begin bad++; $display("FAIL sat_first got=%0d exp=1000", bus.acc_sum); end
    idle(1, 1'b1);
    total++;
    if (bus.acc_sum !== 10'd1023) begin bad++; $display("FAIL sat_clip got=%0d exp=1023", bus.acc_sum); end
    tick(1'b1, 0, 0, 2, 1, 1'b1, 1'b0);
    idle(LAT, 1'b1);
    total++;
    if (bus.acc_sum !== 10'd1023 || bus.res_cnt !== 8'd3) begin bad++; $display("FAIL sat_hold got=%0d/%0d exp=1023/3", bus.acc_sum, bus.res_cnt); end
    tick(1'b1, 3, 3, 2, 1, 1'b1, 1'b0);
    idle(LAT - 1, 1'b1);
    tick(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
    total++;
    if (bus.acc_sum !== 10'd7 || bus.res_cnt !== 8'd1) begin bad++; $display("FAIL sat_clr_add got=%0d/%0d exp=7/1", bus.acc_sum, bus.res_cnt); end
    idle(2, 1'b1);
  endtask

  task automatic test_reset_mid();
    rnd_issue(1'b0);
    idle(LAT, 1'b0);
    rnd_issue(1'b0);
    rnd_issue(1'b0);
    rst_n = 1'b0;
    #1;
    total += 3;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin bad++; $display("FAIL rmid_out got=%b/%0d exp=0/0", bus.out_valid, bus.out_data); end
    if (bus.acc_sum !== '0 || bus.res_cnt !== 8'd0 || bus.ovf !== 1'b0) begin bad++; $display("FAIL rmid_acc got=%0d/%0d/%b exp=0/0/0", bus.acc_sum, bus.res_cnt, bus.ovf); end
    if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", bus.issue_ready); end
    @(negedge clk1);
    rst_n = 1'b1;
    model_reset();
    idle(LAT + 2, 1'b0);
    total += 2;
    if (bus.out_valid !== 1'b0 || bus.res_cnt !== 8'd0) begin bad++; $display("FAIL rmid_nocap got=%b/%0d exp=0/0", bus.out_valid, bus.res_cnt); end
    if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_after got=%b exp=1", bus.issue_ready); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      rnd_issue(1'b1);
      total += 2;
      if (bus.res_cnt !== 8'(cnt_m)) begin bad++; $display("FAIL b2b_cnt_%0d got=%0d exp=%0d", i, bus.res_cnt, cnt_m); end
      if (bus.out_valid !== (fifo_q.size() > 0)) begin bad++; $display("FAIL b2b_valid_%0d got=%b exp=%b", i, bus.out_valid, fifo_q.size() > 0); end
    end
    idle(LAT + 1, 1'b1);
    total++;
    if (bus.res_cnt !== 8'd8 || bus.ovf !== 1'b0) begin bad++; $display("FAIL b2b_total got=%0d/%b exp=8/0", bus.res_cnt, bus.ovf); end
  endtask

  task automatic test_random();
    bit iss, rdy, clr;
    for (int i = 0; i < 400; i++) begin
      iss = ($urandom_range(0, 3) != 0) && (m_ready() || $urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 40) == 0);
      tick(iss, $urandom_range(0, 1023), $urandom_range(0, 1023),
           $urandom_range(0, 1023), $urandom_range(0, 1023), rdy, clr);
      total += 5;
      if (bus.out_valid !== (fifo_q.size() > 0)) begin bad++; $display("FAIL rnd_valid_%0d got=%b exp=%b", i, bus.out_valid, fifo_q.size() > 0); end
      if (bus.issue_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready_%0d got=%b exp=%b", i, bus.issue_ready, m_ready()); end
      if (bus.acc_sum !== ACC_W'(acc_m)) begin bad++; $display("FAIL rnd_acc_%0d got=%0d exp=%0d", i, bus.acc_sum, acc_m); end
      if (bus.res_cnt !== 8'(cnt_m)) begin bad++; $display("FAIL rnd_cnt_%0d got=%0d exp=%0d", i, bus.res_cnt, cnt_m); end
      if (bus.ovf !== ovf_m) begin bad++; $display("FAIL rnd_ovf_%0d got=%b exp=%b", i, bus.ovf, ovf_m); end
      if (fifo_q.size() > 0) begin
        total++;
        if (bus.out_data !== N'(fifo_q[0])) begin bad++; $display("FAIL rnd_data_%0d got=%0d exp=%0d", i, bus.out_data, fifo_q[0]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    bus.issue     = 1'b0;
    bus.F         = '0;
    bus.out_ready = 1'b0;
    bus.acc_clr   = 1'b0;
    model_reset();
    #12;
    test_reset();
    test_single_op();
    test_credit_full();
    test_overflow();
    test_push_pop_full();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
